// File: rtl/text_term_pkg.sv
// Shared types and key codes for the terminal text-entry controller.
// Optional per-line clear is built in with TEXT_TERM_LINE_CLEAR_EN.
package text_term_pkg;

  typedef enum logic [1:0] {
    CLR_SCREEN = 2'd0,
    IDLE       = 2'd1
`ifdef TEXT_TERM_LINE_CLEAR_EN
    ,
    CLR_LINE   = 2'd2
`endif
  } state_t;

  typedef enum logic {
    FILL_SCREEN = 1'b0,
    FILL_LINE   = 1'b1
  } fill_mode_t;

  localparam logic [7:0] ASC_CR       = 8'h0D;
  localparam logic [7:0] ASC_BS       = 8'h08;
  localparam logic [7:0] ASC_TAB      = 8'h09;
  localparam logic [7:0] ASC_ESC      = 8'h1B;
  localparam logic [7:0] ASC_PRINT_LO = 8'h20;
  localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASC_PRINT_LO) && (c <= ASC_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_term_fill.sv
// Counter-based blank-fill engine shared by screen and line clears.
// Runs from reset so the power-up screen clear needs no start pulse.
module text_term_fill
  import text_term_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int HPOS_W = $clog2(COLS),
  parameter int VPOS_W = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  fill_mode_t        mode,
  input  logic [VPOS_W-1:0] row,
  output logic [HPOS_W-1:0] hpos,
  output logic [VPOS_W-1:0] vpos,
  output logic              write_en,
  output logic              done
);

  localparam logic [HPOS_W-1:0] H_LAST = HPOS_W'(COLS - 1);
  localparam logic [VPOS_W-1:0] V_LAST = VPOS_W'(ROWS - 1);

  logic       active;
  fill_mode_t mode_r;
  logic       last_col;
  logic       last;

  assign last_col = hpos == H_LAST;
  assign last     = last_col &&
                    (mode_r == FILL_LINE || vpos == V_LAST);
  assign write_en = active;
  assign done     = active && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b1;
      mode_r <= FILL_SCREEN;
      hpos   <= '0;
      vpos   <= '0;
    end else if (start) begin
      active <= 1'b1;
      mode_r <= mode;
      hpos   <= '0;
      vpos   <= (mode == FILL_LINE) ? row : '0;
    end else if (active) begin
      if (last) begin
        active <= 1'b0;
      end else if (last_col) begin
        hpos <= '0;
        vpos <= vpos + 1'b1;
      end else begin
        hpos <= hpos + 1'b1;
      end
    end
  end

endmodule

// File: rtl/text_term_ctrl.sv
// Terminal text-entry controller feeding a character buffer write port.
// TEXT_TERM_LINE_CLEAR_EN adds a blank fill of each newly entered row.
module text_term_ctrl
  import text_term_pkg::*;
#(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 25,
  parameter int         HPOS_W     = $clog2(COLS),
  parameter int         VPOS_W     = $clog2(ROWS),
  parameter int         TAB_W      = 8,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_ascii_vld,
  input  logic [7:0]        ps2_ascii,
  input  logic              ps2_scancode_vld,
  input  logic [7:0]        ps2_scancode,
  output logic              char_write_en,
  output logic [HPOS_W-1:0] char_hpos,
  output logic [VPOS_W-1:0] char_vpos,
  output logic [7:0]        char_symbol,
  output logic [HPOS_W-1:0] cursor_hpos,
  output logic [VPOS_W-1:0] cursor_vpos,
  output logic              busy,
  output logic              dropped
);

  localparam logic [HPOS_W-1:0] H_LAST = HPOS_W'(COLS - 1);
  localparam logic [VPOS_W-1:0] V_LAST = VPOS_W'(ROWS - 1);
  localparam logic [HPOS_W:0]   TAB_M  = (HPOS_W + 1)'(TAB_W - 1);

  state_t state;
  logic   brk;

  logic acc;
  logic a_go;
  logic s_go;
  logic is_prn;
  logic is_cr;
  logic is_bs;
  logic is_tab;
  logic is_esc;

  assign acc    = (state == IDLE) && !busy;
  assign a_go   = acc && ps2_ascii_vld;
  assign s_go   = acc && ps2_scancode_vld && !ps2_ascii_vld;
  assign is_prn = is_printable(ps2_ascii);
  assign is_cr  = ps2_ascii == ASC_CR;
  assign is_bs  = ps2_ascii == ASC_BS;
  assign is_tab = ps2_ascii == ASC_TAB;
  assign is_esc = ps2_ascii == ASC_ESC;

  logic [VPOS_W-1:0] v_nxt;
  logic [HPOS_W:0]   tab_sum;
  logic [HPOS_W-1:0] tab_h;

  assign v_nxt   = (cursor_vpos == V_LAST) ? '0
                 : cursor_vpos + 1'b1;
  // Round up to the next tab stop, then clamp to the last column
  assign tab_sum = ({1'b0, cursor_hpos} | TAB_M) + 1'b1;
  assign tab_h   = (tab_sum > {1'b0, H_LAST}) ? H_LAST
                 : tab_sum[HPOS_W-1:0];

  logic              fill_start;
  fill_mode_t        fill_mode;
  logic [VPOS_W-1:0] fill_row;
  logic [HPOS_W-1:0] fill_h;
  logic [VPOS_W-1:0] fill_v;
  logic              fill_we;
  logic              fill_done;

`ifdef TEXT_TERM_LINE_CLEAR_EN
  logic row_go;
  assign row_go = a_go &&
    (is_cr || (is_prn && cursor_hpos == H_LAST));
  assign fill_start = (a_go && is_esc) || row_go;
  assign fill_mode  = (a_go && is_esc) ? FILL_SCREEN
                    : FILL_LINE;
  assign fill_row   = v_nxt;
`else
  assign fill_start = a_go && is_esc;
  assign fill_mode  = FILL_SCREEN;
  assign fill_row   = '0;
`endif

  text_term_fill #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .HPOS_W (HPOS_W),
    .VPOS_W (VPOS_W)
  ) u_fill (
    .clk      (clk),
    .rst      (rst),
    .start    (fill_start),
    .mode     (fill_mode),
    .row      (fill_row),
    .hpos     (fill_h),
    .vpos     (fill_v),
    .write_en (fill_we),
    .done     (fill_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CLR_SCREEN;
      brk           <= 1'b0;
      cursor_hpos   <= '0;
      cursor_vpos   <= '0;
      char_write_en <= 1'b0;
      char_hpos     <= '0;
      char_vpos     <= '0;
      char_symbol   <= '0;
      busy          <= 1'b1;
      dropped       <= 1'b0;
    end else begin
      char_write_en <= 1'b0;
      dropped <= busy &&
        (ps2_ascii_vld || ps2_scancode_vld);
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (a_go) begin
            unique case (1'b1)
              is_prn: begin
                char_write_en <= 1'b1;
                char_hpos     <= cursor_hpos;
                char_vpos     <= cursor_vpos;
                char_symbol   <= ps2_ascii;
                if (cursor_hpos == H_LAST) begin
                  cursor_hpos <= '0;
                  cursor_vpos <= v_nxt;
                end else begin
                  cursor_hpos <= cursor_hpos + 1'b1;
                end
              end
              is_cr: begin
                cursor_hpos <= '0;
                cursor_vpos <= v_nxt;
              end
              is_bs: begin
                if (cursor_hpos != '0) begin
                  cursor_hpos   <= cursor_hpos - 1'b1;
                  char_write_en <= 1'b1;
                  char_hpos     <= cursor_hpos - 1'b1;
                  char_vpos     <= cursor_vpos;
                  char_symbol   <= BLANK_CHAR;
                end
              end
              is_tab: cursor_hpos <= tab_h;
              is_esc: begin
                cursor_hpos <= '0;
                cursor_vpos <= '0;
                state       <= CLR_SCREEN;
                busy        <= 1'b1;
              end
              default: ;
            endcase
`ifdef TEXT_TERM_LINE_CLEAR_EN
            if (row_go) begin
              state <= CLR_LINE;
              busy  <= 1'b1;
            end
`endif
          end else if (s_go) begin
            if (brk) begin
              brk <= 1'b0;
            end else begin
              case (ps2_scancode)
                SC_BREAK: brk <= 1'b1;
                SC_LEFT: if (cursor_hpos != '0)
                  cursor_hpos <= cursor_hpos - 1'b1;
                SC_RIGHT: if (cursor_hpos != H_LAST)
                  cursor_hpos <= cursor_hpos + 1'b1;
                SC_UP: if (cursor_vpos != '0)
                  cursor_vpos <= cursor_vpos - 1'b1;
                SC_DOWN: if (cursor_vpos != V_LAST)
                  cursor_vpos <= cursor_vpos + 1'b1;
                SC_EXT: ;
                default: ;
              endcase
            end
          end
        end
        default: begin
          // Both clear states just stream the fill engine's cells
          busy          <= 1'b1;
          char_write_en <= fill_we;
          char_hpos     <= fill_h;
          char_vpos     <= fill_v;
          char_symbol   <= BLANK_CHAR;
          if (fill_done) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Directed bench for text_term_ctrl (80x25, tab 8).
// Line-clear checks follow TEXT_TERM_LINE_CLEAR_EN.
module tb_text_term_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_ascii_vld;
  logic [7:0] ps2_ascii;
  logic       ps2_scancode_vld;
  logic [7:0] ps2_scancode;
  logic       char_write_en;
  logic [6:0] char_hpos;
  logic [4:0] char_vpos;
  logic [7:0] char_symbol;
  logic [6:0] cursor_hpos;
  logic [4:0] cursor_vpos;
  logic       busy;
  logic       dropped;

  text_term_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .ps2_ascii_vld    (ps2_ascii_vld),
    .ps2_ascii        (ps2_ascii),
    .ps2_scancode_vld (ps2_scancode_vld),
    .ps2_scancode     (ps2_scancode),
    .char_write_en    (char_write_en),
    .char_hpos        (char_hpos),
    .char_vpos        (char_vpos),
    .char_symbol      (char_symbol),
    .cursor_hpos      (cursor_hpos),
    .cursor_vpos      (cursor_vpos),
    .busy             (busy),
    .dropped          (dropped)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int nw, nrow, nsym, nbusy, ndrop, lh, lv;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h",
               tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes at a negedge; return at the next one
  task automatic step(input logic av, input logic [7:0] a,
                      input logic sv, input logic [7:0] s);
    ps2_ascii_vld    = av;
    ps2_ascii        = a;
    ps2_scancode_vld = sv;
    ps2_scancode     = s;
    @(negedge clk);
    ps2_ascii_vld    = 1'b0;
    ps2_scancode_vld = 1'b0;
  endtask

  task automatic key(input logic [7:0] a);
    step(1'b1, a, 1'b0, 8'h00);
  endtask

  task automatic sc(input logic [7:0] s);
    step(1'b0, 8'h00, 1'b1, s);
  endtask

  task automatic drain(input int row, input int bound);
    int g;
    g = 0;
    nw = 0; nrow = 0; nsym = 0;
    nbusy = 0; ndrop = 0; lh = -1; lv = -1;
    while (busy && g < bound) begin
      nbusy++;
      if (char_write_en) begin
        nw++;
        lh = int'(char_hpos);
        lv = int'(char_vpos);
        if (char_symbol != 8'h20) nsym++;
        if (row >= 0 && int'(char_vpos) != row) nrow++;
      end
      if (dropped) ndrop++;
      g++;
      @(negedge clk);
    end
    check("drain_timeout", 32'(busy), 32'd0);
  endtask

  task automatic cur(input string tag,
                     input int h, input int v);
    check({tag, "_h"}, 32'(cursor_hpos), 32'(h));
    check({tag, "_v"}, 32'(cursor_vpos), 32'(v));
  endtask

  initial begin
    rst = 1'b1;
    ps2_ascii_vld = 1'b0;
    ps2_ascii = 8'h00;
    ps2_scancode_vld = 1'b0;
    ps2_scancode = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_we", 32'(char_write_en), 32'd0);
    check("rst_drop", 32'(dropped), 32'd0);
    check("rst_sym", 32'(char_symbol), 32'd0);
    cur("rst_cur", 0, 0);

    rst = 1'b0;
    @(negedge clk);
    drain(-1, 5000);
    check("clr_busy_cyc", 32'(nbusy), 32'd2000);
    check("clr_writes", 32'(nw), 32'd2000);
    check("clr_sym", 32'(nsym), 32'd0);
    check("clr_last_h", 32'(lh), 32'd79);
    check("clr_last_v", 32'(lv), 32'd24);
    cur("clr_cur", 0, 0);

    // Reach (79,3) then type 'A' to wrap
    repeat (3) sc(8'h72);
    repeat (10) key(8'h09);
    cur("pre_a", 79, 3);
    key(8'h41);
    check("a_we", 32'(char_write_en), 32'd1);
    check("a_h", 32'(char_hpos), 32'd79);
    check("a_v", 32'(char_vpos), 32'd3);
    check("a_sym", 32'(char_symbol), 32'h41);
    cur("a_cur", 0, 4);
`ifdef TEXT_TERM_LINE_CLEAR_EN
    check("a_lc_busy", 32'(busy), 32'd1);
    @(negedge clk);
    drain(4, 500);
    check("a_lc_writes", 32'(nw), 32'd80);
    check("a_lc_row", 32'(nrow), 32'd0);
    check("a_lc_sym", 32'(nsym), 32'd0);
`else
    check("a_busy", 32'(busy), 32'd0);
`endif

    repeat (20) sc(8'h72);
    cur("pre_cr", 0, 24);
    key(8'h0D);
    check("cr_we", 32'(char_write_en), 32'd0);
    cur("cr_cur", 0, 0);
`ifdef TEXT_TERM_LINE_CLEAR_EN
    @(negedge clk);
    drain(0, 500);
    check("cr_lc_writes", 32'(nw), 32'd80);
    check("cr_lc_row", 32'(nrow), 32'd0);
`endif

    key(8'h08);
    check("bs0_we", 32'(char_write_en), 32'd0);
    cur("bs0_cur", 0, 0);
    key(8'h78);
    check("x_we", 32'(char_write_en), 32'd1);
    check("x_h", 32'(char_hpos), 32'd0);
    check("x_sym", 32'(char_symbol), 32'h78);
    cur("x_cur", 1, 0);
    repeat (4) key(8'h78);
    key(8'h08);
    check("bs_we", 32'(char_write_en), 32'd1);
    check("bs_h", 32'(char_hpos), 32'd4);
    check("bs_v", 32'(char_vpos), 32'd0);
    check("bs_sym", 32'(char_symbol), 32'h20);
    cur("bs_cur", 4, 0);

    sc(8'hF0);
    sc(8'h6B);
    cur("brk_cur", 4, 0);
    sc(8'hE0);
    sc(8'h6B);
    cur("ext_cur", 3, 0);
    repeat (3) sc(8'h6B);
    repeat (7) sc(8'h72);
    sc(8'h6B);
    cur("lclamp", 0, 7);
    repeat (30) sc(8'h72);
    cur("dclamp", 0, 24);
    sc(8'h75);
    cur("up", 0, 23);
    sc(8'h72);

    repeat (3) sc(8'h74);
    key(8'h09);
    check("tab3_we", 32'(char_write_en), 32'd0);
    cur("tab3", 8, 24);
    repeat (69) sc(8'h74);
    cur("pre_tab77", 77, 24);
    key(8'h09);
    check("tab77_we", 32'(char_write_en), 32'd0);
    cur("tab77", 79, 24);
    sc(8'h74);
    cur("rclamp", 79, 24);

    repeat (9) sc(8'h6B);
    step(1'b1, 8'h42, 1'b1, 8'h74);
    check("sim_we", 32'(char_write_en), 32'd1);
    check("sim_h", 32'(char_hpos), 32'd70);
    check("sim_sym", 32'(char_symbol), 32'h42);
    check("sim_drop", 32'(dropped), 32'd0);
    cur("sim_cur", 71, 24);

    key(8'h1B);
    check("esc_busy", 32'(busy), 32'd1);
    cur("esc_cur", 0, 0);
    repeat (9) @(negedge clk);
    key(8'h43);
    check("busy_drop", 32'(dropped), 32'd1);
    check("busy_sym", 32'(char_symbol), 32'h20);
    @(negedge clk);
    check("drop_pulse", 32'(dropped), 32'd0);
    drain(-1, 5000);
    check("esc_more_drop", 32'(ndrop), 32'd0);
    check("esc_sym", 32'(nsym), 32'd0);
    check("esc_last_h", 32'(lh), 32'd79);
    check("esc_last_v", 32'(lv), 32'd24);
    cur("esc_end", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
